// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: serialized loads and
// byte-lane stores into a word array with a programmable number of wait states.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_byte,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        wr_done,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        cap_wr;
  logic [31:0] cap_addr;
  logic [3:0]  cap_byte;
  logic [31:0] cap_data;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          unused;

  logic [31:0] mem [DEPTH_WORDS];

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign offset   = cap_addr - BASE_ADDR;
  assign in_range = ({2'b00, offset[31:2]} < DEPTH_WORDS);
  assign idx      = offset[AW+1:2];
  assign unused   = ^offset[1:0];

  assign rd_ready = (state == IDLE);
  assign wr_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      cap_wr   <= 1'b0;
      cap_addr <= 32'h0;
      cap_byte <= 4'h0;
      cap_data <= 32'h0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      bus_err  <= 1'b0;
      rd_data  <= 32'h0;
    end else begin
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          // Stores win a simultaneous request; the load stays pending upstream.
          if (wr_req) begin
            cap_wr   <= 1'b1;
            cap_addr <= wr_addr;
            cap_byte <= wr_byte;
            cap_data <= wr_data;
          end else if (rd_req) begin
            cap_wr   <= 1'b0;
            cap_addr <= rd_addr;
          end
          if (wr_req || rd_req) begin
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          bus_err <= !in_range;
          if (cap_wr) begin
            wr_done <= 1'b1;
          end else begin
            rd_valid <= 1'b1;
            rd_data  <= in_range ? mem[idx] : 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared by reset; only enabled lanes of an in-range store change.
  always_ff @(posedge clk) begin
    if (state == DONE && cap_wr && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_byte[i]) begin
          mem[idx][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with no wait states and one
// with three, sharing request signals and selected by sel.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_byte = 4'h0;

  logic        rd_req0, wr_req0, rd_req3, wr_req3;
  logic        rd_ready0, rd_valid0, wr_ready0, wr_done0, bus_err0;
  logic        rd_ready3, rd_valid3, wr_ready3, wr_done3, bus_err3;
  logic [31:0] rd_data0, rd_data3;

  logic        rd_ready_s, wr_ready_s, rd_valid_s, wr_done_s, bus_err_s, pulse_s;
  logic [31:0] rd_data_s;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] model [2][4096];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign rd_req0 = rd_req && !sel;
  assign wr_req0 = wr_req && !sel;
  assign rd_req3 = rd_req && sel;
  assign wr_req3 = wr_req && sel;

  assign rd_ready_s = sel ? rd_ready3 : rd_ready0;
  assign wr_ready_s = sel ? wr_ready3 : wr_ready0;
  assign rd_valid_s = sel ? rd_valid3 : rd_valid0;
  assign wr_done_s  = sel ? wr_done3  : wr_done0;
  assign bus_err_s  = sel ? bus_err3  : bus_err0;
  assign rd_data_s  = sel ? rd_data3  : rd_data0;
  assign pulse_s    = rd_valid_s | wr_done_s;

  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .rd_req(rd_req0), .rd_addr(rd_addr), .rd_ready(rd_ready0),
    .rd_valid(rd_valid0), .rd_data(rd_data0),
    .wr_req(wr_req0), .wr_addr(wr_addr), .wr_byte(wr_byte), .wr_data(wr_data),
    .wr_ready(wr_ready0), .wr_done(wr_done0), .bus_err(bus_err0)
  );

  dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .reset(reset),
    .rd_req(rd_req3), .rd_addr(rd_addr), .rd_ready(rd_ready3),
    .rd_valid(rd_valid3), .rd_data(rd_data3),
    .wr_req(wr_req3), .wr_addr(wr_addr), .wr_byte(wr_byte), .wr_data(wr_data),
    .wr_ready(wr_ready3), .wr_done(wr_done3), .bus_err(bus_err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected completion for a request, computed from the bench's own memory model.
  function automatic void push(input bit w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
    exp_t        e;
    logic [11:0] i;
    bit          inr;
    i   = a[13:2];
    inr = ((a >> 2) < 32'd4096);
    e.is_rd = !w;
    e.err   = !inr;
    e.data  = 32'h0;
    if (w && inr) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) model[sel][i][8*k +: 8] = d[8*k +: 8];
      end
    end
    if (!w && inr) e.data = model[sel][i];
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (reset && pulse_s) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'b0, rd_valid_s, wr_done_s}, 32'h0);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", {30'b0, rd_valid_s, wr_done_s}, mon_e.is_rd ? 32'd2 : 32'd1);
        check("bus_err", {31'b0, bus_err_s}, {31'b0, mon_e.err});
        if (mon_e.is_rd) check("rd_data", rd_data_s, mon_e.data);
      end
    end
  end

  // Drives one request, returning at the falling edge after it was accepted.
  task automatic apply_stimulus(input bit w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input bit track);
    int n;
    if (track) push(w, a, b, d);
    if (w) begin
      wr_req = 1'b1; wr_addr = a; wr_byte = b; wr_data = d;
    end else begin
      rd_req = 1'b1; rd_addr = a;
    end
    n = 0;
    while (!(w ? wr_ready_s : rd_ready_s) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (q.size() != 0 && n < 60);
    if (q.size() != 0) begin
      check("completion_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  // Called at the falling edge right after acceptance.
  task automatic check_output(input int ws, input string tag);
    for (int k = 1; k <= ws + 1; k++) begin
      check({tag, "_busy_ready"}, {31'b0, rd_ready_s}, 32'd0);
      check({tag, "_busy_pulse"}, {31'b0, pulse_s}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_pulse"}, {31'b0, pulse_s}, 32'd1);
    check({tag, "_ready"}, {31'b0, wr_ready_s}, 32'd1);
    @(negedge clk);
    check({tag, "_pulse_len"}, {31'b0, pulse_s}, 32'd0);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check("rst_rd_valid", {31'b0, rd_valid0}, 32'd0);
    check("rst_wr_done", {31'b0, wr_done0}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err0}, 32'd0);
    check("rst_rd_data", rd_data0, 32'h0);
    check("rst_ready", {31'b0, rd_ready0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    apply_stimulus(1'b1, 32'h10, 4'hf, 32'hDEADBEEF, 1'b1);
    check_output(0, "ws0_store");
    wait_done();
    apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    check_output(0, "ws0_load");
    wait_done();
    check("rd_data_hold", rd_data0, 32'hDEADBEEF);

    apply_stimulus(1'b1, 32'h20, 4'hf, 32'h11223344, 1'b1);
    apply_stimulus(1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 1'b1);
    apply_stimulus(1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("lane_merge", rd_data0, 32'h11AA3344);
    apply_stimulus(1'b1, 32'h20, 4'h0, 32'h55555555, 1'b1);
    apply_stimulus(1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("no_lane_store", rd_data0, 32'h11AA3344);

    push(1'b1, 32'h40, 4'hf, 32'hCAFEF00D);
    push(1'b0, 32'h40, 4'h0, 32'h0);
    wr_req = 1'b1; wr_addr = 32'h40; wr_byte = 4'hf; wr_data = 32'hCAFEF00D;
    rd_req = 1'b1; rd_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    check("prio_busy", {31'b0, rd_ready0}, 32'd0);
    n = 0;
    while (!rd_ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    wait_done();
    check("prio_data", rd_data0, 32'hCAFEF00D);

    apply_stimulus(1'b1, 32'h0, 4'hf, 32'h01020304, 1'b1);
    apply_stimulus(1'b0, 32'h4000, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("oor_rd_data", rd_data0, 32'h0);
    apply_stimulus(1'b1, 32'h4000, 4'hf, 32'hFFFFFFFF, 1'b1);
    apply_stimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("oor_no_write", rd_data0, 32'h01020304);

    sel = 1'b1;
    apply_stimulus(1'b1, 32'h10, 4'hf, 32'h12345678, 1'b1);
    apply_stimulus(1'b1, 32'h14, 4'hf, 32'h99999999, 1'b1);
    wait_done();
    apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    rd_addr = 32'h14;
    check_output(3, "ws3_load");
    wait_done();
    check("ws3_data", rd_data3, 32'h12345678);

    apply_stimulus(1'b1, 32'h30, 4'hf, 32'h0BADF00D, 1'b1);
    wait_done();
    apply_stimulus(1'b1, 32'h30, 4'hf, 32'h55555555, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", {31'b0, rd_ready3}, 32'd1);
    check("midrst_pulses", {29'b0, rd_valid3, wr_done3, bus_err3}, 32'd0);
    check("midrst_rd_data", rd_data3, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b0, 32'h30, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("midrst_dropped", rd_data3, 32'h0BADF00D);

    sel = 1'b0;
    apply_stimulus(1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    wait_done();
    check("mem_kept_over_reset", rd_data0, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
